// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
//   Two-port (instruction fetch / data) arbiter in front of a single memory
//   handshake (MFA request, MFC complete). Ties are resolved round-robin. After
//   reset the last grant is IF, so DATA wins the first tie. The granted
//   command is latched at grant time and held stable for the whole access.
//
//   Optional feature: define MEM_TIMEOUT_EN to abort an access that sees no
//   MFC within TIMEOUT_CYCLES access cycles. The aborted access completes
//   with ERR=1, and the granted read-data register is cleared.
//
// Ports
//   Clk, Reset                  clock, async active-high reset
//   IF_REQ, IF_ADDR             fetch request (always a word read)
//   IF_DONE, IF_RDATA           fetch completion pulse / read data
//   DATA_REQ, DATA_RW, DATA_WB,
//   DATA_ADDR, DATA_WDATA       data request (RW 1=read, WB 1=word)
//   DATA_DONE, DATA_RDATA       data completion pulse / read data
//   MFA, READ_WRITE, WORD_BYTE,
//   MEMADD, MEM_WDATA           memory command
//   MEM_RDATA, MFC              memory response
//   ERR                         timeout flag, valid with the DONE pulse
module mem_access_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic        IF_DONE,
  output logic [31:0] IF_RDATA,
  input  logic        DATA_REQ,
  input  logic        DATA_RW,
  input  logic        DATA_WB,
  input  logic [31:0] DATA_ADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        DATA_DONE,
  output logic [31:0] DATA_RDATA,
  output logic        MFA,
  output logic        READ_WRITE,
  output logic        WORD_BYTE,
  output logic [31:0] MEMADD,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA,
  input  logic        MFC,
  output logic        ERR
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q;
  logic        grant_data_q;   // 1: current transfer belongs to the DATA port
  logic        last_data_q;    // 1: most recent grant went to DATA
  logic        rw_q;
  logic        wb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] data_rdata_q;
  logic        mfa_q;
  logic        if_done_q;
  logic        data_done_q;
  logic        grant_data_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_cnt_q;
  logic       err_q;
`endif

  // A lone request wins; on a tie, the port not granted last wins.
  always_comb begin
    grant_data_d = DATA_REQ && !(IF_REQ && last_data_q);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      grant_data_q <= 1'b0;
      last_data_q  <= 1'b0;
      rw_q         <= 1'b1;
      wb_q         <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      data_rdata_q <= '0;
      mfa_q        <= 1'b0;
      if_done_q    <= 1'b0;
      data_done_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      if_done_q   <= 1'b0;
      data_done_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (IF_REQ || DATA_REQ) begin
            grant_data_q <= grant_data_d;
            last_data_q  <= grant_data_d;
            if (grant_data_d) begin
              rw_q    <= DATA_RW;
              wb_q    <= DATA_WB;
              addr_q  <= DATA_ADDR;
              wdata_q <= DATA_WDATA;
            end else begin
              // Fetch: word read; write-data register deliberately untouched.
              rw_q   <= 1'b1;
              wb_q   <= 1'b1;
              addr_q <= IF_ADDR;
            end
            mfa_q   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt_q <= '0;
`endif
            state_q <= ACCESS;
          end
        end

        ACCESS: begin
          if (MFC) begin
            if (rw_q) begin
              if (grant_data_q) data_rdata_q <= MEM_RDATA;
              else              if_rdata_q   <= MEM_RDATA;
            end
            mfa_q       <= 1'b0;
            if_done_q   <= !grant_data_q;
            data_done_q <= grant_data_q;
            state_q     <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          // MFC takes priority above, so a response on the expiry edge
          // still completes normally.
          else if (tmo_cnt_q == TMO_LAST) begin
            if (grant_data_q) data_rdata_q <= '0;
            else              if_rdata_q   <= '0;
            mfa_q       <= 1'b0;
            err_q       <= 1'b1;
            if_done_q   <= !grant_data_q;
            data_done_q <= grant_data_q;
            state_q     <= DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
          end
`endif
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign MFA        = mfa_q;
  assign READ_WRITE = rw_q;
  assign WORD_BYTE  = wb_q;
  assign MEMADD     = addr_q;
  assign MEM_WDATA  = wdata_q;
  assign IF_DONE    = if_done_q;
  assign DATA_DONE  = data_done_q;
  assign IF_RDATA   = if_rdata_q;
  assign DATA_RDATA = data_rdata_q;
`ifdef MEM_TIMEOUT_EN
  assign ERR        = err_q;
`else
  assign ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Testbench for mem_access_arbiter: transfer-level reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_access_arbiter;

  localparam int unsigned TO = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        IF_REQ = 1'b0;
  logic [31:0] IF_ADDR = '0;
  logic        IF_DONE;
  logic [31:0] IF_RDATA;
  logic        DATA_REQ = 1'b0;
  logic        DATA_RW = 1'b1;
  logic        DATA_WB = 1'b1;
  logic [31:0] DATA_ADDR = '0;
  logic [31:0] DATA_WDATA = '0;
  logic        DATA_DONE;
  logic [31:0] DATA_RDATA;
  logic        MFA;
  logic        READ_WRITE;
  logic        WORD_BYTE;
  logic [31:0] MEMADD;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA = '0;
  logic        MFC = 1'b0;
  logic        ERR;

  int unsigned checks = 0;
  int unsigned errors = 0;

  mem_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_DONE(IF_DONE), .IF_RDATA(IF_RDATA),
    .DATA_REQ(DATA_REQ), .DATA_RW(DATA_RW), .DATA_WB(DATA_WB),
    .DATA_ADDR(DATA_ADDR), .DATA_WDATA(DATA_WDATA),
    .DATA_DONE(DATA_DONE), .DATA_RDATA(DATA_RDATA),
    .MFA(MFA), .READ_WRITE(READ_WRITE), .WORD_BYTE(WORD_BYTE),
    .MEMADD(MEMADD), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MFC(MFC), .ERR(ERR)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one transfer record) ----------------
  bit          m_busy, m_fin, m_is_data, m_err, m_last_data, m_rw, m_wb;
  int unsigned m_waited;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_data_rdata;

  task m_reset();
    m_busy = 0; m_fin = 0; m_is_data = 0; m_err = 0; m_last_data = 0;
    m_rw = 1; m_wb = 1; m_waited = 0;
    m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_data_rdata = '0;
  endtask

  task m_edge();
    if (m_busy && m_fin) begin
      m_busy = 0;                       // completion cycle: requests ignored
    end else if (m_busy) begin
      if (MFC) begin
        if (m_rw) begin
          if (m_is_data) m_data_rdata = MEM_RDATA;
          else           m_if_rdata   = MEM_RDATA;
        end
        m_fin = 1; m_err = 0;
      end else begin
        m_waited++;
`ifdef MEM_TIMEOUT_EN
        if (m_waited >= TO) begin
          m_fin = 1; m_err = 1;
          if (m_is_data) m_data_rdata = '0;
          else           m_if_rdata   = '0;
        end
`endif
      end
    end else if (IF_REQ || DATA_REQ) begin
      m_is_data = DATA_REQ && !(IF_REQ && m_last_data);
      m_last_data = m_is_data;
      m_busy = 1; m_fin = 0; m_err = 0; m_waited = 0;
      if (m_is_data) begin
        m_rw = DATA_RW; m_wb = DATA_WB; m_addr = DATA_ADDR; m_wdata = DATA_WDATA;
      end else begin
        m_rw = 1; m_wb = 1; m_addr = IF_ADDR;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) m_reset();
      else       m_edge();
    end
  end

  // every-cycle comparison on the falling edge
  initial begin
    forever begin
      @(negedge Clk);
      chk("cyc_MFA",        MFA,        32'(m_busy && !m_fin));
      chk("cyc_IF_DONE",    IF_DONE,    32'(m_busy && m_fin && !m_is_data));
      chk("cyc_DATA_DONE",  DATA_DONE,  32'(m_busy && m_fin && m_is_data));
      chk("cyc_ERR",        ERR,        32'(m_busy && m_fin && m_err));
      chk("cyc_READ_WRITE", READ_WRITE, 32'(m_rw));
      chk("cyc_WORD_BYTE",  WORD_BYTE,  32'(m_wb));
      chk("cyc_MEMADD",     MEMADD,     m_addr);
      chk("cyc_MEM_WDATA",  MEM_WDATA,  m_wdata);
      chk("cyc_IF_RDATA",   IF_RDATA,   m_if_rdata);
      chk("cyc_DATA_RDATA", DATA_RDATA, m_data_rdata);
    end
  end

  // ---------------- memory responder ----------------
  int unsigned mfc_delay = 0;
  bit          mfc_force = 0;
  int unsigned acnt = 0;

  initial begin
    forever begin
      @(posedge Clk);
      #3;
      if (MFA === 1'b1) acnt++;
      else              acnt = 0;
      MFC = ((MFA === 1'b1) && (acnt > mfc_delay)) || mfc_force;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step(); step();
    Reset = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, input bit scramble,
                           output int unsigned steps, output int unsigned mfa_n,
                           output bit got_if, output bit got_data, output bit got_err,
                           output logic [31:0] c_addr, output logic [31:0] c_wdata,
                           output bit c_rw, output bit c_wb);
    bit seen = 0;
    steps = 0; mfa_n = 0; got_if = 0; got_data = 0; got_err = 0;
    c_addr = '0; c_wdata = '0; c_rw = 0; c_wb = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      step();
      steps++;
      if (MFA === 1'b1) begin
        if (mfa_n == 0) begin
          c_addr = MEMADD; c_wdata = MEM_WDATA; c_rw = READ_WRITE; c_wb = WORD_BYTE;
          if (scramble) begin
            DATA_ADDR = ~DATA_ADDR; DATA_WDATA = ~DATA_WDATA;
            DATA_RW = ~DATA_RW; DATA_WB = ~DATA_WB; IF_ADDR = ~IF_ADDR;
          end
        end
        mfa_n++;
      end
      if (IF_DONE === 1'b1 || DATA_DONE === 1'b1) begin
        got_if = IF_DONE; got_data = DATA_DONE; got_err = ERR;
        seen = 1;
        break;
      end
    end
    chk("done_within_budget", 32'(seen), 32'd1);
  endtask

  int unsigned steps, mfa_n;
  bit          g_if, g_data, g_err, c_rw, c_wb;
  logic [31:0] c_addr, c_wdata;

  initial begin
    Reset = 1'b1;
    step(); step();
    // reset values
    chk("rst_MFA", MFA, 32'd0);
    chk("rst_RW", READ_WRITE, 32'd1);
    chk("rst_WB", WORD_BYTE, 32'd1);
    chk("rst_MEMADD", MEMADD, 32'd0);
    chk("rst_IF_RDATA", IF_RDATA, 32'd0);
    chk("rst_DONE", 32'({IF_DONE, DATA_DONE, ERR}), 32'd0);
    Reset = 1'b0;
    step();

    // fetch read, minimum latency
    IF_REQ = 1; IF_ADDR = 32'h100; MEM_RDATA = 32'hE3A01005; mfc_delay = 0;
    wait_done(20, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    IF_REQ = 0;
    chk("fetch_steps", steps, 32'd2);
    chk("fetch_mfa_cycles", mfa_n, 32'd1);
    chk("fetch_done_port", 32'({g_if, g_data}), 32'b10);
    chk("fetch_addr", c_addr, 32'h100);
    chk("fetch_rw_wb", 32'({c_rw, c_wb}), 32'b11);
    chk("fetch_rdata", IF_RDATA, 32'hE3A01005);
    step();

    // data word read
    DATA_REQ = 1; DATA_RW = 1; DATA_WB = 1; DATA_ADDR = 32'h40;
    DATA_WDATA = 32'h5555_0000; MEM_RDATA = 32'h1234_5678; mfc_delay = 2;
    wait_done(20, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    DATA_REQ = 0;
    chk("dread_mfa_cycles", mfa_n, 32'd3);
    chk("dread_done_port", 32'({g_if, g_data}), 32'b01);
    chk("dread_rdata", DATA_RDATA, 32'h1234_5678);
    chk("dread_if_rdata_kept", IF_RDATA, 32'hE3A01005);
    step();

    // byte write, delayed MFC, inputs scrambled after grant
    DATA_REQ = 1; DATA_RW = 0; DATA_WB = 0; DATA_ADDR = 32'h23;
    DATA_WDATA = 32'hAB; MEM_RDATA = 32'hDEAD_BEEF; mfc_delay = 4;
    wait_done(30, 1, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    DATA_REQ = 0;
    chk("bwr_mfa_cycles", mfa_n, 32'd5);
    chk("bwr_done_port", 32'({g_if, g_data}), 32'b01);
    chk("bwr_rw_wb", 32'({c_rw, c_wb}), 32'b00);
    chk("bwr_addr", c_addr, 32'h23);
    chk("bwr_wdata", c_wdata, 32'hAB);
    chk("bwr_memadd_held", MEMADD, 32'h23);
    chk("bwr_rdata_kept", DATA_RDATA, 32'h1234_5678);
    step();

    // fetch after a write: MEM_WDATA keeps the write data
    IF_REQ = 1; IF_ADDR = 32'h104; MEM_RDATA = 32'hE1A0_0000; mfc_delay = 1;
    wait_done(20, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    IF_REQ = 0;
    chk("fetch2_mfa_cycles", mfa_n, 32'd2);
    chk("fetch2_wdata_held", c_wdata, 32'hAB);
    chk("fetch2_rw_wb", 32'({c_rw, c_wb}), 32'b11);
    chk("fetch2_rdata", IF_RDATA, 32'hE1A0_0000);
    step();

    // MFC while idle is ignored
    mfc_force = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_mfc_no_mfa", MFA, 32'd0);
      chk("idle_mfc_no_done", 32'({IF_DONE, DATA_DONE}), 32'd0);
    end
    mfc_force = 0;
    step();

    // tie arbitration with both requests held from reset
    IF_REQ = 1; IF_ADDR = 32'h200;
    DATA_REQ = 1; DATA_RW = 1; DATA_WB = 1; DATA_ADDR = 32'h300; DATA_WDATA = 32'h0;
    MEM_RDATA = 32'h0BAD_F00D; mfc_delay = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      wait_done(20, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
      chk($sformatf("tie%0d_port", k), 32'({g_if, g_data}), (k % 2 == 0) ? 32'b01 : 32'b10);
      chk($sformatf("tie%0d_addr", k), c_addr, (k % 2 == 0) ? 32'h300 : 32'h200);
      chk($sformatf("tie%0d_steps", k), steps, (k == 0) ? 32'd2 : 32'd3);
    end
    IF_REQ = 0; DATA_REQ = 0;
    step(); step();

    // reset in the middle of an access
    IF_REQ = 1; IF_ADDR = 32'h500; mfc_delay = 1000;
    step(); step(); step();
    chk("midrst_pre_mfa", MFA, 32'd1);
    Reset = 1'b1;
    #1;
    chk("midrst_mfa_drop", MFA, 32'd0);
    chk("midrst_no_done", 32'({IF_DONE, DATA_DONE}), 32'd0);
    IF_REQ = 0;
    step();
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_idle_mfa", MFA, 32'd0);
      chk("midrst_idle_done", 32'({IF_DONE, DATA_DONE}), 32'd0);
    end

`ifdef MEM_TIMEOUT_EN
    // prime DATA_RDATA, then let the access time out
    DATA_REQ = 1; DATA_RW = 1; DATA_WB = 1; DATA_ADDR = 32'h60; MEM_RDATA = 32'hCAFE_F00D;
    mfc_delay = 0;
    wait_done(20, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    DATA_REQ = 0;
    chk("tmo_prime_rdata", DATA_RDATA, 32'hCAFE_F00D);
    step();
    DATA_REQ = 1; mfc_delay = 1000;
    wait_done(50, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    DATA_REQ = 0;
    chk("tmo_mfa_cycles", mfa_n, 32'd4);
    chk("tmo_err", 32'(g_err), 32'd1);
    chk("tmo_done_port", 32'({g_if, g_data}), 32'b01);
    chk("tmo_rdata_zero", DATA_RDATA, 32'd0);
    step();
    // MFC on the expiry edge wins
    DATA_REQ = 1; MEM_RDATA = 32'h7777_1111; mfc_delay = 3;
    wait_done(50, 0, steps, mfa_n, g_if, g_data, g_err, c_addr, c_wdata, c_rw, c_wb);
    DATA_REQ = 0;
    chk("tmo_race_mfa_cycles", mfa_n, 32'd4);
    chk("tmo_race_err", 32'(g_err), 32'd0);
    chk("tmo_race_rdata", DATA_RDATA, 32'h7777_1111);
    step();
`else
    // no timeout: access waits for MFC indefinitely
    begin
      int unsigned hi = 0, errs = 0, dones = 0;
      IF_REQ = 1; IF_ADDR = 32'h600; mfc_delay = 1000;
      step();
      for (int i = 0; i < 100; i++) begin
        if (MFA === 1'b1) hi++;
        if (ERR !== 1'b0) errs++;
        if (IF_DONE === 1'b1 || DATA_DONE === 1'b1) dones++;
        step();
      end
      chk("nomfc_mfa_cycles", hi, 32'd100);
      chk("nomfc_err", errs, 32'd0);
      chk("nomfc_done", dones, 32'd0);
      IF_REQ = 0;
      do_reset();
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
